// File: rtl/output_drain_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : output_drain_ctrl
// Purpose  : Buffers completed pixel groups (GROUP_SIZE parallel channel words
//            plus coordinates) in a small FIFO and serialises them one word
//            per cycle onto a valid/ready stream, tagging each word with its
//            x, y and absolute channel index.
// Revision : 1.0 - initial release
// ============================================================================
module output_drain_ctrl #(
   parameter int DATA_WIDTH = 32,
   parameter int GROUP_SIZE = 6,
   parameter int FIFO_DEPTH = 2
) (
   input  logic                             clk,
   input  logic                             arst_n_in,
   input  logic                             grp_valid,
   input  logic [GROUP_SIZE*DATA_WIDTH-1:0] grp_data,
   input  logic [31:0]                      grp_x,
   input  logic [31:0]                      grp_y,
   input  logic [31:0]                      grp_ch_base,
   output logic                             grp_stall,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [DATA_WIDTH-1:0]            out_data,
   output logic [31:0]                      out_x,
   output logic [31:0]                      out_y,
   output logic [31:0]                      out_ch,
   output logic                             busy
);

   localparam int LANE_W = (GROUP_SIZE > 1) ? $clog2(GROUP_SIZE) : 1;
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = PTR_W + 1;

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_DRAIN = 1'b1;

   localparam logic [LANE_W-1:0] c_last_lane = LANE_W'(GROUP_SIZE - 1);
   localparam logic [CNT_W-1:0]  c_full      = CNT_W'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0]  c_stall_lvl = CNT_W'(FIFO_DEPTH - 1);

   // Group storage; the data array is split per lane so the drain can index it directly
   logic [GROUP_SIZE-1:0][DATA_WIDTH-1:0] r_data_mem [FIFO_DEPTH];
   logic [31:0]                           r_x_mem    [FIFO_DEPTH];
   logic [31:0]                           r_y_mem    [FIFO_DEPTH];
   logic [31:0]                           r_ch_mem   [FIFO_DEPTH];

   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [CNT_W-1:0]  r_count;
   logic [CNT_W-1:0]  w_count_nxt;
   logic              r_overflow_err;

   logic [0:0]        r_state;
   logic [0:0]        w_state_nxt;
   logic [LANE_W-1:0] r_lane;
   logic [LANE_W-1:0] w_lane_nxt;

   logic              w_full;
   logic              w_push;
   logic              w_pop;

   // A full FIFO refuses pushes even if the head is popped in the same cycle
   assign w_full = (r_count == c_full);
   assign w_push = grp_valid & ~w_full;
   assign w_pop  = (r_state == S_DRAIN) & out_ready & (r_lane == c_last_lane);

   // Occupancy after this cycle's push/pop
   always_comb begin
      w_count_nxt = r_count;
      case ({w_push, w_pop})
         2'b10:   w_count_nxt = r_count + 1'b1;
         2'b01:   w_count_nxt = r_count - 1'b1;
         default: w_count_nxt = r_count;
      endcase
   end

   // Write the accepted group into the slot at the write pointer
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_data_mem[r_wr_ptr] <= grp_data;
         r_x_mem[r_wr_ptr]    <= grp_x;
         r_y_mem[r_wr_ptr]    <= grp_y;
         r_ch_mem[r_wr_ptr]   <= grp_ch_base;
      end
   end

   // Pointers, occupancy and the sticky overflow flag; pointers wrap naturally (power-of-two depth)
   always_ff @(posedge clk or negedge arst_n_in) begin
      if (!arst_n_in) begin
         r_wr_ptr       <= '0;
         r_rd_ptr       <= '0;
         r_count        <= '0;
         r_overflow_err <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count        <= w_count_nxt;
         r_overflow_err <= r_overflow_err | (grp_valid & w_full);
      end
   end

   // FSM state and lane counter register
   always_ff @(posedge clk or negedge arst_n_in) begin
      if (!arst_n_in) begin
         r_state <= S_IDLE;
         r_lane  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_lane  <= w_lane_nxt;
      end
   end

   // Next state: stay in DRAIN across group boundaries if a group (incl. one pushed now) remains
   always_comb begin
      w_state_nxt = r_state;
      w_lane_nxt  = r_lane;
      case (r_state)
         S_IDLE: begin
            if (r_count != '0) begin
               w_state_nxt = S_DRAIN;
               w_lane_nxt  = '0;
            end
         end
         S_DRAIN: begin
            if (out_ready) begin
               if (r_lane == c_last_lane) begin
                  w_lane_nxt = '0;
                  if (w_count_nxt == '0) w_state_nxt = S_IDLE;
               end else begin
                  w_lane_nxt = r_lane + 1'b1;
               end
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_lane_nxt  = '0;
         end
      endcase
   end

   // Outputs: head-group word and tags while draining, zero otherwise
   always_comb begin
      out_valid = 1'b0;
      out_data  = '0;
      out_x     = '0;
      out_y     = '0;
      out_ch    = '0;
      if (r_state == S_DRAIN) begin
         out_valid = 1'b1;
         out_data  = r_data_mem[r_rd_ptr][r_lane];
         out_x     = r_x_mem[r_rd_ptr];
         out_y     = r_y_mem[r_rd_ptr];
         out_ch    = r_ch_mem[r_rd_ptr] + {{(32-LANE_W){1'b0}}, r_lane};
      end
      busy      = (r_count != '0) | (r_state == S_DRAIN);
      grp_stall = (r_count >= c_stall_lvl);
   end

endmodule
`default_nettype wire

// File: tb/tb_output_drain_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_output_drain_ctrl
// Purpose  : Directed scoreboard bench for output_drain_ctrl. Stimulus pushes
//            expected words into a queue; a monitor pops and compares every
//            accepted output word and checks stability under backpressure.
// Revision : 1.0 - initial release
// ============================================================================
module tb_output_drain_ctrl;

   localparam int DW = 32;
   localparam int GS = 6;
   localparam int FD = 2;

   logic             clk = 1'b0;
   logic             arst_n_in;
   logic             grp_valid;
   logic [GS*DW-1:0] grp_data;
   logic [31:0]      grp_x, grp_y, grp_ch_base;
   logic             grp_stall;
   logic             out_valid;
   logic             out_ready;
   logic [DW-1:0]    out_data;
   logic [31:0]      out_x, out_y, out_ch;
   logic             busy;

   typedef struct packed {
      logic [31:0] d;
      logic [31:0] x;
      logic [31:0] y;
      logic [31:0] ch;
   } beat_t;

   beat_t sb[$];
   int    n_cmp = 0;
   int    n_err = 0;

   output_drain_ctrl #(
      .DATA_WIDTH (DW),
      .GROUP_SIZE (GS),
      .FIFO_DEPTH (FD)
   ) dut (
      .clk         (clk),
      .arst_n_in   (arst_n_in),
      .grp_valid   (grp_valid),
      .grp_data    (grp_data),
      .grp_x       (grp_x),
      .grp_y       (grp_y),
      .grp_ch_base (grp_ch_base),
      .grp_stall   (grp_stall),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_x       (out_x),
      .out_y       (out_y),
      .out_ch      (out_ch),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Present one group for one edge; queue its six expected words if it should be accepted
   task automatic push_grp(input logic [31:0] x, input logic [31:0] y, input logic [31:0] ch,
                           input logic [31:0] d0, input bit accept);
      beat_t b;
      grp_valid   = 1'b1;
      grp_x       = x;
      grp_y       = y;
      grp_ch_base = ch;
      for (int i = 0; i < GS; i++) begin
         grp_data[i*DW +: DW] = d0 + 32'(i);
         if (accept) begin
            b.d  = d0 + 32'(i);
            b.x  = x;
            b.y  = y;
            b.ch = ch + 32'(i);
            sb.push_back(b);
         end
      end
      cyc();
      grp_valid = 1'b0;
   endtask

   task automatic wait_valid(input string name);
      int i;
      for (i = 0; i < 50 && !out_valid; i++) cyc();
      chk(name, {31'd0, out_valid}, 32'd1);
   endtask

   task automatic wait_idle(input string name);
      int i;
      for (i = 0; i < 200 && busy; i++) cyc();
      chk({name, "_idle"}, {31'd0, busy}, 32'd0);
      chk({name, "_sb_empty"}, sb.size(), 32'd0);
   endtask

   // Monitor: compare each accepted word against the scoreboard; held words must not change
   initial begin : monitor
      beat_t e;
      beat_t hold;
      bit    hold_v;
      hold_v = 1'b0;
      forever begin
         @(negedge clk);
         if (!arst_n_in || !out_valid) begin
            hold_v = 1'b0;
         end else begin
            if (hold_v) begin
               chk("hold_data", out_data, hold.d);
               chk("hold_ch", out_ch, hold.ch);
            end
            if (out_ready) begin
               hold_v = 1'b0;
               if (sb.size() == 0) begin
                  n_cmp++;
                  n_err++;
                  $display("FAIL unexpected_word: got data %h ch %h expected none", out_data, out_ch);
               end else begin
                  e = sb.pop_front();
                  chk("word_data", out_data, e.d);
                  chk("word_x", out_x, e.x);
                  chk("word_y", out_y, e.y);
                  chk("word_ch", out_ch, e.ch);
               end
            end else begin
               hold_v = 1'b1;
               hold.d  = out_data;
               hold.ch = out_ch;
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int i;
      arst_n_in   = 1'b0;
      grp_valid   = 1'b0;
      grp_data    = '0;
      grp_x       = '0;
      grp_y       = '0;
      grp_ch_base = '0;
      out_ready   = 1'b0;
      #2;
      // Reset state
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_grp_stall", {31'd0, grp_stall}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_out_data", out_data, 32'd0);
      chk("rst_out_ch", out_ch, 32'd0);
      chk("rst_out_xy", out_x | out_y, 32'd0);
      chk("rst_overflow", {31'd0, dut.r_overflow_err}, 32'd0);
      cyc();
      cyc();
      arst_n_in = 1'b1;
      cyc();

      // Single group: six consecutive words then idle
      out_ready = 1'b1;
      push_grp(32'd3, 32'd5, 32'd12, 32'd100, 1'b1);
      wait_valid("single_first_valid");
      for (i = 0; i < GS; i++) begin
         chk("single_consecutive", {31'd0, out_valid}, 32'd1);
         cyc();
      end
      chk("single_end_valid", {31'd0, out_valid}, 32'd0);
      wait_idle("single");

      // Backpressure at lane 2 for four cycles
      out_ready = 1'b0;
      push_grp(32'd3, 32'd5, 32'd12, 32'd100, 1'b1);
      wait_valid("bp_first_valid");
      out_ready = 1'b1;
      cyc();
      cyc();
      out_ready = 1'b0;
      for (i = 0; i < 4; i++) begin
         chk("bp_data", out_data, 32'd102);
         chk("bp_ch", out_ch, 32'd14);
         cyc();
      end
      out_ready = 1'b1;
      wait_idle("bp");

      // Fill: two accepted, third ignored with sticky overflow
      out_ready = 1'b0;
      chk("fill_ovf_before", {31'd0, dut.r_overflow_err}, 32'd0);
      push_grp(32'd7, 32'd8, 32'd100, 32'd1000, 1'b1);
      chk("fill_stall_1", {31'd0, grp_stall}, 32'd1);
      push_grp(32'd9, 32'd10, 32'd200, 32'd2000, 1'b1);
      chk("fill_stall_2", {31'd0, grp_stall}, 32'd1);
      push_grp(32'd11, 32'd12, 32'd300, 32'd3000, 1'b0);
      chk("fill_ovf_after", {31'd0, dut.r_overflow_err}, 32'd1);
      out_ready = 1'b1;
      wait_idle("fill");

      // Back-to-back: B pushed in the cycle A's last lane pops
      push_grp(32'd1, 32'd2, 32'd40, 32'd500, 1'b1);
      for (i = 0; i < 50 && !(out_valid && out_ch == 32'd45); i++) cyc();
      chk("b2b_found_lane5", out_ch, 32'd45);
      push_grp(32'd1, 32'd3, 32'd60, 32'd600, 1'b1);
      chk("b2b_no_gap_valid", {31'd0, out_valid}, 32'd1);
      chk("b2b_no_gap_ch", out_ch, 32'd60);
      wait_idle("b2b");

      // Channel wrap-around: FFFFFFFE, FFFFFFFF, 0, 1, 2, 3
      push_grp(32'd0, 32'd0, 32'hFFFF_FFFE, 32'd700, 1'b1);
      wait_valid("wrap_first_valid");
      chk("wrap_ch0", out_ch, 32'hFFFF_FFFE);
      cyc();
      cyc();
      chk("wrap_ch2", out_ch, 32'h0000_0000);
      wait_idle("wrap");

      // Reset while draining lane 3
      out_ready = 1'b0;
      push_grp(32'd4, 32'd4, 32'd80, 32'd800, 1'b1);
      wait_valid("rstmid_first_valid");
      out_ready = 1'b1;
      cyc();
      cyc();
      cyc();
      out_ready = 1'b0;
      chk("rstmid_lane3_ch", out_ch, 32'd83);
      arst_n_in = 1'b0;
      #1;
      chk("rstmid_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rstmid_busy", {31'd0, busy}, 32'd0);
      chk("rstmid_out_data", out_data, 32'd0);
      chk("rstmid_ovf", {31'd0, dut.r_overflow_err}, 32'd0);
      sb.delete();
      cyc();
      cyc();
      arst_n_in = 1'b1;
      out_ready = 1'b1;
      for (i = 0; i < 20; i++) cyc();
      chk("rstmid_quiet_busy", {31'd0, busy}, 32'd0);

      // Normal operation resumes after a new push
      push_grp(32'd6, 32'd7, 32'd90, 32'd900, 1'b1);
      wait_idle("post_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/output_drain_ctrl.md
OUTPUT_DRAIN_CTRL -- requirements
Module: output_drain_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of one output word.
REQ-002 SHALL have parameter GROUP_SIZE, default 6: output channels computed in parallel per pixel group.
REQ-003 SHALL have parameter FIFO_DEPTH, default 2: pixel groups buffered; power of two, at least 2.
REQ-004 SHALL have port clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-005 SHALL have port arst_n_in, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port grp_valid, input, 1 bit: the controller presents a completed pixel group.
REQ-007 SHALL have port grp_data, input, GROUP_SIZE*DATA_WIDTH bits: group words; lane i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have ports grp_x, grp_y, grp_ch_base, input, 32 bits each: pixel coordinates and the first channel of the group.
REQ-009 SHALL have port grp_stall, output, 1 bit: the controller must hold its pipeline and must not assert grp_valid.
REQ-010 SHALL have ports out_valid and out_ready, output and input, 1 bit each: downstream handshake.
REQ-011 SHALL have port out_data, output, DATA_WIDTH bits, and ports out_x, out_y, out_ch, output, 32 bits each: the current word and its coordinates.
REQ-012 SHALL have port busy, output, 1 bit: the FIFO is non-empty or a drain is in progress.

Function
REQ-013 SHALL accept a group on every rising edge where grp_valid=1 and the FIFO is not full, writing data and coordinates to the write slot.
REQ-014 SHALL ignore grp_valid while the FIFO is full, and SHALL raise an internal sticky overflow_err flag; the flag is cleared only by reset.
REQ-015 SHALL drive grp_stall=1 when occupancy is at least FIFO_DEPTH-1, or when occupancy equals FIFO_DEPTH.
REQ-016 SHALL use a 2-state FSM, IDLE and DRAIN, with a lane counter of width $clog2(GROUP_SIZE).
REQ-017 In IDLE, the FSM SHALL stay in IDLE when the FIFO is empty, and SHALL move to DRAIN with lane=0 when the FIFO is non-empty; the first out_valid appears the cycle after entry to DRAIN.
REQ-018 In DRAIN, out_valid SHALL be 1 and the outputs SHALL be driven as follows:
- out_data = lane [lane] of the head group;
- out_x = head x, out_y = head y;
- out_ch = head ch_base + lane, 32-bit wrap-around addition.
REQ-019 SHALL hold all out_* values stable while out_valid=1 and out_ready=0.
REQ-020 On out_valid and out_ready with lane < GROUP_SIZE-1, SHALL increment lane.
REQ-021 On out_valid and out_ready with lane = GROUP_SIZE-1, SHALL pop the head and reset lane to 0; it SHALL stay in DRAIN if another group remains after the pop, otherwise return to IDLE.
REQ-022 SHALL support a push and a pop in the same cycle with occupancy unchanged; a push into a full FIFO is not valid even when a pop happens in the same cycle.
REQ-023 Read and write pointers SHALL wrap modulo FIFO_DEPTH; occupancy SHALL be a counter of width $clog2(FIFO_DEPTH)+1.
REQ-024 SHALL sustain one output word per cycle when out_ready=1 continuously, with no bubble between groups.
REQ-025 busy SHALL be 1 when occupancy is not 0 or the state is DRAIN.

Reset
REQ-026 On arst_n_in=0, independent of clk, SHALL clear the following:
- FSM to IDLE, lane=0;
- pointers and occupancy to 0;
- overflow_err to 0;
- out_valid, grp_stall and busy to 0;
- out_data, out_x, out_y and out_ch to 0.
REQ-027 A reset asserted mid-drain SHALL discard all buffered groups; after release, no output appears until a new push.

Verification
REQ-028 Single group: push x=3, y=5, ch_base=12, lanes 100..105, out_ready=1 -> 6 consecutive out_valid cycles, ch 12..17, data 100..105, then IDLE.
REQ-029 Backpressure: out_ready=0 for 4 cycles during lane 2 -> out_data=102 and out_ch=14 held stable; the sequence resumes without loss or duplication.
REQ-030 Fill: two pushes with out_ready=0 -> grp_stall=1 after the first push; a third grp_valid is ignored and overflow_err=1; draining gives 12 words in push order.
REQ-031 Back-to-back: push group A, then push group B in the cycle A's lane 5 pops -> B lane 0 follows A lane 5 with no gap.
REQ-032 Wrap: ch_base=0xFFFFFFFE -> out_ch = FFFFFFFE, FFFFFFFF, 0, 1, 2, 3.
REQ-033 Reset mid-drain at lane 3 -> out_valid=0 immediately, busy=0, no further words after release.
